tof_frame_buffer: RTL and testbench

// - Downstream of the ToF sensor FSM: captures per-zone distance samples (distance_data/sensor_index/data_ready).
// - Assembles them into complete 8x8 frames in a ping-pong buffer.
// - Presents the latest complete frame to a reader (UART/display) via a random-access read port with frame handshake.

---
 rtl/tof_pkg.sv | 22 ++
 rtl/tof_frame_dpram.sv | 40 ++++
 rtl/tof_frame_buffer.sv | 186 ++++++++++++++++++
 tb/tb_tof_frame_buffer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tof_pkg.sv
// Shared constants and state types for the ToF frame buffer.
// ZONES zones per frame (power of two), DIST_W-bit distance samples in mm,
// CNT_W-bit frame/overrun counters.
package tof_pkg;

    localparam int ZONES  = 64;
    localparam int DIST_W = 16;
    localparam int IDX_W  = $clog2(ZONES);
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_FILL   = 2'd1,
        WR_COMMIT = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_EMPTY = 1'b0,
        RD_HELD  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/tof_frame_dpram.sv
// Simple dual-port RAM holding both frame banks, 2*ZONES x DIST_W.
// Address is {bank, zone index}. One write port, one registered read port.
// Ports:
//   clk, reset        clock, synchronous active-high reset (read register only)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i      read strobe and address
//   rdata_o           read data, valid the cycle after re_i
module tof_frame_dpram
    import tof_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [IDX_W:0]    waddr_i,
    input  logic [DIST_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W:0]    raddr_i,
    output logic [DIST_W-1:0] rdata_o
);

    logic [DIST_W-1:0] mem_q [2*ZONES];
    logic [DIST_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tof_frame_buffer.sv
// Assembles per-zone ToF distance samples into complete frames in a
// ping-pong buffer and presents the latest complete frame to a reader.
// Optional feature macro: TOF_MIN_TRACK_EN adds min_dist/min_index, the
// nearest non-zero target of the frame held for the reader.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_ready_lvl               sample strobe level; only its rising edge counts
//   in_index, in_data          zone index and distance for that edge
//   rd_req, rd_index           read strobe and zone from the held frame
//   rd_data, rd_valid          read result, one cycle after rd_req
//   frame_ready                a complete frame is held for the reader
//   frame_ack                  reader releases the held frame
//   frame_err                  held frame had missing zones
//   frame_count                committed frames (wraps)
//   overrun_count              frames dropped while held (saturates)
//   min_dist, min_index        (TOF_MIN_TRACK_EN only) minimum of held frame
module tof_frame_buffer
    import tof_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_ready_lvl,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [DIST_W-1:0] in_data,
    input  logic              rd_req,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [DIST_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  overrun_count
`ifdef TOF_MIN_TRACK_EN
    ,
    output logic [DIST_W-1:0] min_dist,
    output logic [IDX_W-1:0]  min_index
`endif
);

    wr_state_t          wr_state_q, wr_state_d;
    rd_state_t          rd_state_q, rd_state_d;
    logic               rdy_d_q;
    logic               wr_bank_q, wr_bank_d;
    logic [ZONES-1:0]   mask_q, mask_d;
    logic               frame_err_q, frame_err_d;
    logic [CNT_W-1:0]   frame_count_q, frame_count_d;
    logic [CNT_W-1:0]   overrun_q, overrun_d;
    logic               rd_valid_q;

    logic               cap, start, we, commit, swap, drop;

    always_comb begin
        cap        = in_ready_lvl & ~rdy_d_q;
        start      = cap && (in_index == '0);
        wr_state_d = wr_state_q;
        mask_d     = mask_q;
        we         = 1'b0;
        commit     = 1'b0;
        case (wr_state_q)
            // A frame only ever begins at zone 0; COMMIT also accepts it so
            // back-to-back frames lose no sample.
            WR_IDLE, WR_COMMIT: begin
                commit     = (wr_state_q == WR_COMMIT);
                wr_state_d = WR_IDLE;
                if (start) begin
                    we         = 1'b1;
                    mask_d     = ZONES'(1);
                    wr_state_d = WR_FILL;
                end
            end
            WR_FILL: begin
                if (cap) begin
                    we     = 1'b1;
                    mask_d = start ? ZONES'(1) : (mask_q | (ZONES'(1) << in_index));
                    if (in_index == IDX_W'(ZONES - 1)) begin
                        wr_state_d = WR_COMMIT;
                    end
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        swap          = commit & ((rd_state_q == RD_EMPTY) | frame_ack);
        drop          = commit & ~swap;
        wr_bank_d     = wr_bank_q ^ swap;
        rd_state_d    = rd_state_q;
        frame_err_d   = frame_err_q;
        frame_count_d = frame_count_q + CNT_W'(commit);
        overrun_d     = (drop && !(&overrun_q)) ? overrun_q + CNT_W'(1) : overrun_q;
        if (swap) begin
            rd_state_d  = RD_HELD;
            frame_err_d = ~&mask_q;
        end else if ((rd_state_q == RD_HELD) && frame_ack) begin
            rd_state_d  = RD_EMPTY;
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q    <= WR_IDLE;
            rd_state_q    <= RD_EMPTY;
            rdy_d_q       <= 1'b0;
            wr_bank_q     <= 1'b0;
            mask_q        <= '0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            rd_state_q    <= rd_state_d;
            rdy_d_q       <= in_ready_lvl;
            wr_bank_q     <= wr_bank_d;
            mask_q        <= mask_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            rd_valid_q    <= rd_req;
        end
    end

    // Both ports use the post-swap bank: a zone-0 write in the commit cycle
    // lands in the fresh bank, and a read in the swap cycle sees the new frame.
    tof_frame_dpram u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we),
        .waddr_i ({wr_bank_d, in_index}),
        .wdata_i (in_data),
        .re_i    (rd_req),
        .raddr_i ({~wr_bank_d, rd_index}),
        .rdata_o (rd_data)
    );

    assign rd_valid      = rd_valid_q;
    assign frame_ready   = (rd_state_q == RD_HELD);
    assign frame_err     = frame_err_q;
    assign frame_count   = frame_count_q;
    assign overrun_count = overrun_q;

`ifdef TOF_MIN_TRACK_EN
    logic [DIST_W-1:0] run_min_q, run_min_d, min_dist_q;
    logic [IDX_W-1:0]  run_idx_q, run_idx_d, min_index_q;
    logic              hit;

    // Zero means no target and never becomes the minimum.
    always_comb begin
        hit       = (in_data != '0);
        run_min_d = run_min_q;
        run_idx_d = run_idx_q;
        if (we) begin
            if (start) begin
                run_min_d = hit ? in_data : '1;
                run_idx_d = '0;
            end else if (hit && (in_data < run_min_q)) begin
                run_min_d = in_data;
                run_idx_d = in_index;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_min_q   <= '1;
            run_idx_q   <= '0;
            min_dist_q  <= '1;
            min_index_q <= '0;
        end else begin
            run_min_q <= run_min_d;
            run_idx_q <= run_idx_d;
            if (swap) begin
                min_dist_q  <= run_min_q;
                min_index_q <= run_idx_q;
            end
        end
    end

    assign min_dist  = min_dist_q;
    assign min_index = min_index_q;
`endif

endmodule

// File: tb/tb_tof_frame_buffer.sv
module tb_tof_frame_buffer;
    import tof_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_ready_lvl;
    logic [IDX_W-1:0]  in_index;
    logic [DIST_W-1:0] in_data;
    logic              rd_req;
    logic [IDX_W-1:0]  rd_index;
    logic [DIST_W-1:0] rd_data;
    logic              rd_valid;
    logic              frame_ready;
    logic              frame_ack;
    logic              frame_err;
    logic [CNT_W-1:0]  frame_count;
    logic [CNT_W-1:0]  overrun_count;
`ifdef TOF_MIN_TRACK_EN
    logic [DIST_W-1:0] min_dist;
    logic [IDX_W-1:0]  min_index;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        int idx;
        int exp;
    } rd_vec_t;

    rd_vec_t tbl[5];

    tof_frame_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .in_ready_lvl  (in_ready_lvl),
        .in_index      (in_index),
        .in_data       (in_data),
        .rd_req        (rd_req),
        .rd_index      (rd_index),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .frame_ready   (frame_ready),
        .frame_ack     (frame_ack),
        .frame_err     (frame_err),
        .frame_count   (frame_count),
        .overrun_count (overrun_count)
`ifdef TOF_MIN_TRACK_EN
        ,
        .min_dist      (min_dist),
        .min_index     (min_index)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [DIST_W-1:0] dat(input int tag, input int idx);
        if (tag == 7) begin
            if (idx == 9) return DIST_W'(12);
            if ((idx % 2) == 0) return '0;
            return DIST_W'(idx * 10 + 7);
        end
        return DIST_W'(idx * 10 + tag);
    endfunction

    task automatic send(input int idx, input logic [DIST_W-1:0] d, input int hold);
        in_index     = IDX_W'(idx);
        in_data      = d;
        in_ready_lvl = 1'b1;
        repeat (hold) tick();
        in_ready_lvl = 1'b0;
        tick();
    endtask

    task automatic send_frame(input int tag, input int skip, input int last, input int hold);
        for (int i = 0; i <= last; i++) begin
            if (i != skip) send(i, dat(tag, i), hold);
        end
    endtask

    task automatic do_read(input string nm, input int idx, input int exp);
        rd_req   = 1'b1;
        rd_index = IDX_W'(idx);
        tick();
        rd_req = 1'b0;
        chk({nm, "_valid"}, int'(rd_valid), 1);
        chk(nm, int'(rd_data), exp);
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    initial begin
        tbl[0] = '{idx: 0,  exp: 0};
        tbl[1] = '{idx: 5,  exp: 50};
        tbl[2] = '{idx: 17, exp: 170};
        tbl[3] = '{idx: 31, exp: 310};
        tbl[4] = '{idx: 63, exp: 630};

        reset        = 1'b1;
        in_ready_lvl = 1'b0;
        in_index     = '0;
        in_data      = '0;
        rd_req       = 1'b0;
        rd_index     = '0;
        frame_ack    = 1'b0;
        repeat (3) tick();
        chk("rst_ready", int'(frame_ready), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_count", int'(frame_count), 0);
        chk("rst_overrun", int'(overrun_count), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
`ifdef TOF_MIN_TRACK_EN
        chk("rst_min_dist", int'(min_dist), 65535);
        chk("rst_min_index", int'(min_index), 0);
`endif
        reset = 1'b0;
        tick();

        // Frame 1: data = idx*10, latency of zone 63 to frame_ready
        send_frame(0, -1, 62, 1);
        in_index     = IDX_W'(63);
        in_data      = dat(0, 63);
        in_ready_lvl = 1'b1;
        tick();
        chk("lat_capture", int'(frame_ready), 0);
        in_ready_lvl = 1'b0;
        tick();
        chk("lat_commit", int'(frame_ready), 1);
        chk("f1_err", int'(frame_err), 0);
        chk("f1_count", int'(frame_count), 1);
        chk("f1_overrun", int'(overrun_count), 0);
        for (int i = 0; i < 5; i++) begin
            do_read($sformatf("f1_rd%0d", tbl[i].idx), tbl[i].idx, tbl[i].exp);
        end
        tick();
        chk("rd_valid_pulse", int'(rd_valid), 0);
`ifdef TOF_MIN_TRACK_EN
        chk("f1_min_dist", int'(min_dist), 10);
        chk("f1_min_index", int'(min_index), 1);
`endif
        ack();
        chk("ack_release", int'(frame_ready), 0);
        ack();
        chk("ack_empty_ignored", int'(frame_ready), 0);
        chk("ack_empty_count", int'(frame_count), 1);

        // Frame 2: data_ready held 3 cycles per sample
        send_frame(1, -1, 63, 3);
        chk("f2_ready", int'(frame_ready), 1);
        chk("f2_err", int'(frame_err), 0);
        chk("f2_count", int'(frame_count), 2);
        do_read("f2_rd5", 5, 51);
        ack();

        // Frame 3: zone 17 missing, stale value from frame 1 in the same bank
        send_frame(2, 17, 63, 1);
        chk("f3_ready", int'(frame_ready), 1);
        chk("f3_err", int'(frame_err), 1);
        chk("f3_count", int'(frame_count), 3);
        do_read("f3_rd17_stale", 17, 170);
        do_read("f3_rd5", 5, 52);
        ack();
        chk("f3_err_cleared", int'(frame_err), 0);

        // Frames 4 and 5 with no ack: frame 5 dropped
        send_frame(3, -1, 63, 1);
        chk("f4_ready", int'(frame_ready), 1);
        send_frame(4, -1, 63, 1);
        chk("f5_overrun", int'(overrun_count), 1);
        chk("f5_count", int'(frame_count), 5);
        chk("f5_ready", int'(frame_ready), 1);
        chk("f5_err", int'(frame_err), 0);
        do_read("f5_rd5_first", 5, 53);
        do_read("f5_rd63_first", 63, 633);

        // Frame 6: ack and a read in the commit cycle
        send_frame(5, -1, 62, 1);
        in_index     = IDX_W'(63);
        in_data      = dat(5, 63);
        in_ready_lvl = 1'b1;
        tick();
        chk("f6_pre_ready", int'(frame_ready), 1);
        chk("f6_pre_count", int'(frame_count), 5);
        in_ready_lvl = 1'b0;
        frame_ack    = 1'b1;
        rd_req       = 1'b1;
        rd_index     = IDX_W'(5);
        tick();
        frame_ack = 1'b0;
        rd_req    = 1'b0;
        chk("f6_rd_at_swap_valid", int'(rd_valid), 1);
        chk("f6_rd_at_swap", int'(rd_data), 55);
        chk("f6_ready", int'(frame_ready), 1);
        chk("f6_count", int'(frame_count), 6);
        chk("f6_overrun", int'(overrun_count), 1);
        tick();
        chk("f6_ready_stays", int'(frame_ready), 1);
        do_read("f6_rd63", 63, 635);

        // Frame 7 aborted by reset at zone 30
        send_frame(6, -1, 30, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ready", int'(frame_ready), 0);
        chk("mid_rst_count", int'(frame_count), 0);
        chk("mid_rst_overrun", int'(overrun_count), 0);
        chk("mid_rst_err", int'(frame_err), 0);
        chk("mid_rst_rd_data", int'(rd_data), 0);
`ifdef TOF_MIN_TRACK_EN
        chk("mid_rst_min_dist", int'(min_dist), 65535);
`endif
        // Without zone 0 nothing is assembled
        send(40, 16'd99, 1);
        send(63, 16'd99, 1);
        tick();
        chk("no_start_ready", int'(frame_ready), 0);
        chk("no_start_count", int'(frame_count), 0);

        // Frame 8: clean frame after reset, zone 9 = 12 is the nearest target
        send_frame(7, -1, 63, 1);
        chk("f8_ready", int'(frame_ready), 1);
        chk("f8_count", int'(frame_count), 1);
        chk("f8_err", int'(frame_err), 0);
        do_read("f8_rd9", 9, 12);
        do_read("f8_rd5", 5, 57);
        do_read("f8_rd40", 40, 0);
`ifdef TOF_MIN_TRACK_EN
        chk("f8_min_dist", int'(min_dist), 12);
        chk("f8_min_index", int'(min_index), 9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
